// File: rtl/state_readback_if.sv
// -----------------------------------------------------------------------------
// state_readback_if
//   Bundles the two buses of the state readback unit.
//   - Read side: port-A reads on the shared off-chip STATE bus
//     (rd_en / rd_addr out, rd_data back from every PE).
//   - Stream side: valid/ready word stream (valid, data, last out; ready in).
//
// Modports
//   master : the readback unit (drives rd_en/rd_addr/valid/data/last)
//   slave  : STATE memories + downstream consumer (drive rd_data/ready)
// -----------------------------------------------------------------------------
interface state_readback_if #(
    parameter int PE_NUM_WIDTH     = 2,
    parameter int STATE_ADDR_WIDTH = 16,
    parameter int STATE_DATA_WIDTH = 64
);
    localparam int NUM_PE = 2 ** PE_NUM_WIDTH;

    // Read bus towards the per-PE STATE memories
    logic                                     rd_en;
    logic [PE_NUM_WIDTH+STATE_ADDR_WIDTH-1:0] rd_addr;
    logic [NUM_PE*STATE_DATA_WIDTH-1:0]       rd_data;

    // Output word stream
    logic                        valid;
    logic                        ready;
    logic [STATE_DATA_WIDTH-1:0] data;
    logic                        last;

    modport master (
        output rd_en, rd_addr,
        input  rd_data,
        output valid, data, last,
        input  ready
    );

    modport slave (
        input  rd_en, rd_addr,
        output rd_data,
        input  valid, data, last,
        output ready
    );
endinterface

// File: rtl/state_readback_unit.sv
// -----------------------------------------------------------------------------
// state_readback_unit
//   Drains the per-PE STATE memories off-chip. A start walks PE 0..NUM_PE-1
//   and, inside each PE, word addresses base..base+length-1. Each word is read
//   through port A of the shared STATE bus and handed to a valid/ready stream
//   through a small credit-limited FIFO. Reads are only issued when the FIFO
//   is guaranteed to have room for them, so back-pressure never loses data.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous reset, active high (aborts any running job)
//   i_start      start pulse, ignored while o_busy
//   i_base_addr  first word address, same for every PE
//   i_length     words per PE (0 gives an immediate o_done, no reads)
//   o_busy       high from accepted start until completion
//   o_done       one-cycle completion pulse
//   io_bus       state_readback_if.master: read bus + output stream
// -----------------------------------------------------------------------------
module state_readback_unit #(
    parameter int PE_NUM_WIDTH     = 2,
    parameter int STATE_ADDR_WIDTH = 16,
    parameter int STATE_DATA_WIDTH = 64,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_start,
    input  logic [STATE_ADDR_WIDTH-1:0] i_base_addr,
    input  logic [STATE_ADDR_WIDTH:0] i_length,
    output logic                      o_busy,
    output logic                      o_done,
    state_readback_if.master          io_bus
);
    localparam int AW     = STATE_ADDR_WIDTH;
    localparam int DW     = STATE_DATA_WIDTH;
    localparam int PW     = PE_NUM_WIDTH;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [AW:0] LEN_ONE = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } fifo_entry_t;

    // FSM and job registers
    state_t          r_state;
    state_t          w_state_next;
    logic [AW-1:0]   r_base;
    logic [AW:0]     r_len;
    logic [PW-1:0]   r_pe;
    logic [AW:0]     r_idx;
    logic            r_done;

    // Read in flight (issued last cycle, data on i_rd_data this cycle)
    logic            r_inflight;
    logic [PW-1:0]   r_inflight_pe;
    logic            r_inflight_last;

    // Output FIFO
    fifo_entry_t     r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Combinational control
    logic            w_issue;
    logic            w_start_run;
    logic            w_start_empty;
    logic            w_finish;
    logic            w_room;
    logic            w_idx_last;
    logic            w_pe_last;
    logic            w_valid;
    logic            w_push;
    logic            w_pop;
    fifo_entry_t     w_head;
    logic [DW-1:0]   w_rd_word;

    // Credit check: the in-flight read already owns a slot, so count it too.
    // A pop in the same cycle is deliberately not credited back.
    assign w_room     = (r_count + CNT_W'(r_inflight)) < CNT_W'(FIFO_DEPTH);
    assign w_idx_last = (r_idx == r_len - LEN_ONE);
    assign w_pe_last  = &r_pe;

    assign w_head  = r_mem[r_rd_ptr];
    assign w_valid = (r_count != '0);
    assign w_push  = r_inflight;
    assign w_pop   = w_valid & io_bus.ready;

    // Returned word comes from the PE that was addressed one cycle earlier.
    assign w_rd_word = io_bus.rd_data[r_inflight_pe*DW +: DW];

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state and per-cycle strobes
    // -------------------------------------------------------------------------
    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_next  = r_state;
        w_issue       = 1'b0;
        w_start_run   = 1'b0;
        w_start_empty = 1'b0;
        w_finish      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (i_length != '0) begin
                        w_start_run  = 1'b1;
                        w_state_next = S_RUN;
                    end else begin
                        w_start_empty = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (w_room) begin
                    w_issue = 1'b1;
                    if (w_pe_last && w_idx_last) begin
                        w_state_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Words leave in issue order, so popping the tagged last word
                // means nothing is queued or in flight any more.
                if (w_pop && w_head.last) begin
                    w_finish     = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Job parameters, walk counters, in-flight tracking, done pulse
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base          <= '0;
            r_len           <= '0;
            r_pe            <= '0;
            r_idx           <= '0;
            r_done          <= 1'b0;
            r_inflight      <= 1'b0;
            r_inflight_pe   <= '0;
            r_inflight_last <= 1'b0;
        end else begin
            r_done          <= w_start_empty | w_finish;
            r_inflight      <= w_issue;
            r_inflight_pe   <= r_pe;
            r_inflight_last <= w_pe_last & w_idx_last;
            if (w_start_run) begin
                r_base <= i_base_addr;
                r_len  <= i_length;
                r_pe   <= '0;
                r_idx  <= '0;
            end else if (w_issue) begin
                if (w_idx_last) begin
                    r_idx <= '0;
                    r_pe  <= r_pe + PW'(1);
                end else begin
                    r_idx <= r_idx + LEN_ONE;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output FIFO
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // NOTE: the storage array has no reset; emptiness is tracked by r_count,
    // and stale entries are never observable because outputs are gated by it.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{last: r_inflight_last, data: w_rd_word};
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign o_busy = (r_state != S_IDLE);
    assign o_done = r_done;

    assign io_bus.rd_en   = w_issue;
    assign io_bus.rd_addr = w_issue ? {r_pe, r_base + r_idx[AW-1:0]} : '0;

    assign io_bus.valid = w_valid;
    assign io_bus.data  = w_valid ? w_head.data : '0;
    assign io_bus.last  = w_valid & w_head.last;

endmodule

// File: tb/tb_state_readback_unit.sv
// -----------------------------------------------------------------------------
// tb_state_readback_unit
//   Bench for state_readback_unit. Models the per-PE STATE memories as a
//   one-cycle read with a fixed per-(PE, address) data pattern, and checks the
//   issued addresses and streamed words against scoreboard queues filled when
//   each job is started.
// -----------------------------------------------------------------------------
module tb_state_readback_unit;
    localparam int PW = 2;
    localparam int AW = 16;
    localparam int DW = 64;
    localparam int FD = 4;
    localparam int NP = 2 ** PW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base;
    logic [AW:0]   len;
    logic          busy;
    logic          done;

    state_readback_if #(
        .PE_NUM_WIDTH    (PW),
        .STATE_ADDR_WIDTH(AW),
        .STATE_DATA_WIDTH(DW)
    ) bus ();

    state_readback_unit #(
        .PE_NUM_WIDTH    (PW),
        .STATE_ADDR_WIDTH(AW),
        .STATE_DATA_WIDTH(DW),
        .FIFO_DEPTH      (FD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (start),
        .i_base_addr(base),
        .i_length   (len),
        .o_busy     (busy),
        .o_done     (done),
        .io_bus     (bus)
    );

    always #5 clk = ~clk;

    // Scoreboard state
    logic [PW+AW-1:0] exp_addr_q [$];
    logic [DW:0]      exp_word_q [$];
    int n_cmp      = 0;
    int n_err      = 0;
    int cyc        = 0;
    int done_count = 0;
    int rd_pulses  = 0;
    int hs_count   = 0;
    int first_hs   = 0;
    int last_hs    = 0;
    logic chk_lat  = 1'b0;
    logic prev_done = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    function automatic logic [DW-1:0] model(input int pe, input logic [AW-1:0] a);
        return {16'hA5C3, 8'(pe), 8'h3C, a, a ^ 16'(pe * 4369)};
    endfunction

    // STATE memory model: one-cycle registered read, every PE sees the address
    always @(posedge clk) begin
        if (bus.rd_en) begin
            for (int k = 0; k < NP; k++) begin
                bus.rd_data[k*DW +: DW] <= model(k, bus.rd_addr[AW-1:0]);
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rd_en) begin
                rd_pulses++;
                if (exp_addr_q.size() == 0) begin
                    check("rd_en_unexpected", 64'(bus.rd_en), 64'd0);
                end else begin
                    check("rd_addr", 64'(bus.rd_addr), 64'(exp_addr_q.pop_front()));
                end
            end
            if (bus.valid && bus.ready) begin
                if (exp_word_q.size() == 0) begin
                    check("valid_unexpected", 64'(bus.valid), 64'd0);
                end else begin
                    logic [DW:0] w;
                    w = exp_word_q.pop_front();
                    check("data", bus.data, w[DW-1:0]);
                    check("last", 64'(bus.last), 64'(w[DW]));
                end
                if (hs_count == 0) first_hs = cyc;
                last_hs = cyc;
                hs_count++;
            end
            if (done) begin
                done_count++;
                check("done_busy_low", 64'(busy), 64'd0);
                check("done_one_cycle", 64'(prev_done), 64'd0);
                if (chk_lat) check("done_latency", 64'(cyc), 64'(last_hs + 1));
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic check_all_zero(input string pfx);
        check({pfx, "_busy"},    64'(busy),         64'd0);
        check({pfx, "_done"},    64'(done),         64'd0);
        check({pfx, "_rd_en"},   64'(bus.rd_en),    64'd0);
        check({pfx, "_valid"},   64'(bus.valid),    64'd0);
        check({pfx, "_last"},    64'(bus.last),     64'd0);
        check({pfx, "_rd_addr"}, 64'(bus.rd_addr),  64'd0);
        check({pfx, "_data"},    bus.data,          64'd0);
    endtask

    // Push the expected reads/words, then pulse i_start for one cycle
    task automatic start_job(input logic [AW-1:0] b, input logic [AW:0] l);
        for (int p = 0; p < NP; p++) begin
            for (int i = 0; i < int'(l); i++) begin
                logic [AW-1:0] a;
                a = b + AW'(i);
                exp_addr_q.push_back({PW'(p), a});
                exp_word_q.push_back({(p == NP - 1) && (i == int'(l) - 1), model(p, a)});
            end
        end
        @(posedge clk); #1;
        base  = b;
        len   = l;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int dc0);
        int n;
        n = 0;
        while (done_count == dc0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, 64'(done_count - dc0), 64'd1);
        repeat (3) @(negedge clk);
        check({tag, "_single_done"}, 64'(done_count - dc0), 64'd1);
        check({tag, "_addr_q_empty"}, 64'(exp_addr_q.size()), 64'd0);
        check({tag, "_word_q_empty"}, 64'(exp_word_q.size()), 64'd0);
        check({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic reset_mid_cycle(input string tag);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check_all_zero(tag);
        exp_addr_q.delete();
        exp_word_q.delete();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int dc0;
        int rp0;
        int hs0;
        int n;

        rst       = 1'b1;
        start     = 1'b0;
        base      = '0;
        len       = '0;
        bus.ready = 1'b1;

        // 1: reset state, then mid-job asynchronous reset
        #12;
        check_all_zero("reset");
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_reset_busy", 64'(busy), 64'd0);

        dc0 = done_count;
        start_job(16'h0010, 17'd3);
        repeat (5) @(posedge clk);
        reset_mid_cycle("midrst");
        repeat (6) @(negedge clk);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_valid", 64'(bus.valid), 64'd0);
        check("midrst_no_done", 64'(done_count - dc0), 64'd0);

        // 2: base 0x0010, len 3, always ready: 12 words at one per cycle
        chk_lat  = 1'b1;
        hs_count = 0;
        dc0      = done_count;
        start_job(16'h0010, 17'd3);
        wait_done("basic", dc0);
        check("basic_words", 64'(hs_count), 64'd12);
        check("basic_rate", 64'(last_hs - first_hs), 64'd11);

        // 3: same job with a 10-cycle back-pressure window mid-stream
        hs_count = 0;
        dc0      = done_count;
        start_job(16'h0010, 17'd3);
        n = 0;
        while (hs_count < 4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("stall_reached", 64'(hs_count >= 4), 64'd1);
        @(posedge clk); #1;
        bus.ready = 1'b0;
        rp0 = rd_pulses;
        repeat (10) @(negedge clk);
        check("stall_reads_bounded", 64'((rd_pulses - rp0) <= FD), 64'd1);
        check("stall_rd_en_low", 64'(bus.rd_en), 64'd0);
        check("stall_valid_held", 64'(bus.valid), 64'd1);
        check("stall_data_held", bus.data, exp_word_q[0][DW-1:0]);
        @(posedge clk); #1;
        bus.ready = 1'b1;
        wait_done("stall", dc0);
        check("stall_words", 64'(hs_count), 64'd12);

        // 4: address wrap, base 0xFFFE, len 4
        dc0 = done_count;
        start_job(16'hFFFE, 17'd4);
        wait_done("wrap", dc0);

        // 5: zero-length job
        chk_lat = 1'b0;
        dc0     = done_count;
        rp0     = rd_pulses;
        hs0     = hs_count;
        start_job(16'h0123, 17'd0);
        @(negedge clk);
        check("len0_done_pulse", 64'(done), 64'd1);
        check("len0_busy", 64'(busy), 64'd0);
        repeat (5) @(negedge clk);
        check("len0_single_done", 64'(done_count - dc0), 64'd1);
        check("len0_no_reads", 64'(rd_pulses - rp0), 64'd0);
        check("len0_no_words", 64'(hs_count - hs0), 64'd0);

        // 6a: i_start re-pulsed during a job with different parameters
        chk_lat = 1'b1;
        dc0     = done_count;
        start_job(16'h0020, 17'd2);
        @(posedge clk); #1;
        base  = 16'h0300;
        len   = 17'd5;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("restart", dc0);

        // 6b: reset during a job, then a fresh job
        dc0 = done_count;
        start_job(16'h0040, 17'd3);
        repeat (6) @(posedge clk);
        reset_mid_cycle("jobrst");
        repeat (6) @(negedge clk);
        check("jobrst_no_done", 64'(done_count - dc0), 64'd0);
        check("jobrst_fifo_empty", 64'(bus.valid), 64'd0);

        dc0 = done_count;
        start_job(16'h0050, 17'd2);
        wait_done("after_rst", dc0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
